// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the memory port arbiter.
package mem_arb_pkg;

  localparam int WIDTH_DEF      = 32;
  localparam int ADDR_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arb_src_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM stage.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no access in flight; arbitrate and capture the winner
// ISSUE | mem_req high from captured registers until mem_gnt
// WAIT  | request accepted; waiting for the single mem_rvalid
// RESP  | valid pulse to the granted requester, then back to IDLE
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  input  logic               if_kill,
  output logic [WIDTH-1:0]   if_rdata,
  output logic               if_valid,
  input  logic               dm_req,
  input  logic               dm_we,
  input  logic [ADDR_W-1:0]  dm_addr,
  input  logic [WIDTH-1:0]   dm_wdata,
  input  logic [WIDTH/8-1:0] dm_wstrb,
  output logic [WIDTH-1:0]   dm_rdata,
  output logic               dm_valid,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic [WIDTH/8-1:0] mem_wstrb,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic               stall_if,
  output logic               stall_mem
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_t           state;
  arb_src_t             src;
  logic                 drop;
  logic [CNT_W-1:0]     starve_cnt;
  logic [ADDR_W-1:0]    addr_q;
  logic                 we_q;
  logic [WIDTH-1:0]     wdata_q;
  logic [WIDTH/8-1:0]   wstrb_q;

  // A fetch that is being killed in the same cycle does not compete.
  logic if_active;
  logic grant_d;
  logic fetch_kill;

  // Arbitration decision and kill qualifier used by the FSM.
  always_comb begin
    if_active  = if_req & ~if_kill;
    grant_d    = dm_req & ~(if_active & (starve_cnt == STARVE_LIM));
    fetch_kill = (src == SRC_I) & if_kill;
  end

  // Issue/wait/respond sequencer with captured request and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src        <= SRC_I;
      drop       <= 1'b0;
      starve_cnt <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            src     <= SRC_D;
            addr_q  <= dm_addr;
            we_q    <= dm_we;
            wdata_q <= dm_we ? dm_wdata : '0;
            wstrb_q <= dm_we ? dm_wstrb : '0;
            if (if_active && (starve_cnt != STARVE_LIM))
              starve_cnt <= starve_cnt + 1'b1;
            state <= ISSUE;
          end else if (if_active) begin
            src        <= SRC_I;
            addr_q     <= if_addr;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            starve_cnt <= '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // A kill coinciding with the grant cannot retract the request;
          // the response is consumed and discarded instead.
          if (mem_gnt) begin
            state <= WAIT;
            if (fetch_kill) drop <= 1'b1;
          end else if (fetch_kill) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (fetch_kill) drop <= 1'b1;
          if (mem_rvalid) begin
            state <= RESP;
            if (src == SRC_I) begin
              if (!(drop || if_kill)) begin
                if_rdata <= mem_rdata;
                if_valid <= 1'b1;
              end
            end else begin
              dm_valid <= 1'b1;
              if (!we_q) dm_rdata <= mem_rdata;
            end
          end
        end
        RESP: begin
          drop  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side request is a decode of the state plus the captured fields.
  always_comb begin
    mem_req   = (state == ISSUE);
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wstrb = wstrb_q;
  end

  // Hazard-unit stalls follow the requests directly.
  always_comb begin
    stall_if  = if_req & ~if_valid & ~if_kill;
    stall_mem = dm_req & ~dm_valid;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a simple memory responder.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_kill;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;

  mem_port_arbiter #(.WIDTH(32), .ADDR_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } acc_t;

  acc_t        exp_acc[$];
  logic [31:0] exp_if[$];
  logic [31:0] exp_dm[$];

  int vectors;
  int miscompares;

  // memory responder state
  int          gnt_wait;
  int          rv_delay;
  int          rv_wait;
  bit          rv_pend;
  logic [31:0] rv_data;
  bit          dm_hold;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic acc_t mk(input logic [31:0] a, input logic w,
                              input logic [31:0] d, input logic [3:0] s);
    acc_t t;
    t.addr = a; t.we = w; t.wdata = d; t.wstrb = s;
    return t;
  endfunction

  // One cycle: sample outputs at negedge, score responses, run the memory model.
  task automatic tick();
    acc_t e;
    logic [31:0] d;
    @(negedge clk);
    if (if_valid) begin
      if (exp_if.size() == 0) chk("spurious_if_valid", 32'(if_valid), 32'd0);
      else begin d = exp_if.pop_front(); chk("if_rdata", if_rdata, d); end
    end
    if (dm_valid) begin
      if (exp_dm.size() == 0) chk("spurious_dm_valid", 32'(dm_valid), 32'd0);
      else begin d = exp_dm.pop_front(); chk("dm_rdata", dm_rdata, d); end
    end
    mem_rvalid = 1'b0;
    if (rv_pend) begin
      if (rv_wait == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rv_data;
        rv_pend    = 1'b0;
      end else rv_wait--;
    end
    mem_gnt = 1'b0;
    if (mem_req) begin
      if (gnt_wait > 0) gnt_wait--;
      else begin
        mem_gnt = 1'b1;
        if (exp_acc.size() == 0) chk("spurious_access", 32'(mem_req), 32'd0);
        else begin
          e = exp_acc.pop_front();
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", 32'(mem_we), 32'(e.we));
          chk("mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        end
        rv_pend = 1'b1;
        rv_wait = rv_delay;
        rv_data = mem_we ? 32'h0BADF00D : mem_fn(mem_addr);
      end
    end
    if (if_valid) begin
      if_req = 1'b0;
      if (dm_hold) dm_req = 1'b0;
    end
    if (dm_valid && !dm_hold) dm_req = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    gnt_wait = 0; rv_delay = 0; rv_wait = 0; rv_pend = 1'b0; rv_data = '0; dm_hold = 1'b0;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // reset state
    ticks(3);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_dm_valid", 32'(dm_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // fetch only, minimum latency
    if_req = 1'b1; if_addr = 32'h100;
    exp_acc.push_back(mk(32'h100, 1'b0, 32'h0, 4'h0));
    exp_if.push_back(32'h00500093);
    #1 chk("stall_if_c0", 32'(stall_if), 32'd1);
    tick();
    chk("fetch_req_c1", 32'(mem_req), 32'd1);
    chk("stall_if_c1", 32'(stall_if), 32'd1);
    tick();
    chk("stall_if_c2", 32'(stall_if), 32'd1);
    chk("if_valid_c2", 32'(if_valid), 32'd0);
    tick();
    chk("if_valid_c3", 32'(if_valid), 32'd1);
    tick();
    chk("if_valid_c4", 32'(if_valid), 32'd0);

    // simultaneous requests: data first, fetch right after RESP
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000; dm_wstrb = 4'hF; dm_wdata = 32'hFFFF_FFFF;
    exp_acc.push_back(mk(32'h2000, 1'b0, 32'h0, 4'h0));
    exp_acc.push_back(mk(32'h104, 1'b0, 32'h0, 4'h0));
    exp_dm.push_back(mem_fn(32'h2000));
    exp_if.push_back(mem_fn(32'h104));
    #1 chk("stall_mem_c0", 32'(stall_mem), 32'd1);
    ticks(5);
    chk("fetch_after_resp_req", 32'(mem_req), 32'd1);
    chk("fetch_after_resp_addr", mem_addr, 32'h104);
    ticks(5);
    chk("both_if_done", 32'(exp_if.size()), 32'd0);
    chk("both_dm_done", 32'(exp_dm.size()), 32'd0);

    // starvation: four data grants, then fetch is forced
    dm_hold = 1'b1;
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000;
    for (int i = 0; i < 4; i++) begin
      exp_acc.push_back(mk(32'h3000, 1'b0, 32'h0, 4'h0));
      exp_dm.push_back(mem_fn(32'h3000));
    end
    exp_acc.push_back(mk(32'h200, 1'b0, 32'h0, 4'h0));
    exp_if.push_back(mem_fn(32'h200));
    ticks(26);
    dm_hold = 1'b0;
    chk("starve_acc_done", 32'(exp_acc.size()), 32'd0);
    chk("starve_if_done", 32'(exp_if.size()), 32'd0);
    chk("starve_cnt_cleared", 32'(dut.starve_cnt), 32'd0);

    // store
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF; dm_wstrb = 4'b0011;
    exp_acc.push_back(mk(32'h40, 1'b1, 32'hDEADBEEF, 4'b0011));
    exp_dm.push_back(mem_fn(32'h3000));
    ticks(2);
    chk("store_dm_valid_c2", 32'(dm_valid), 32'd0);
    tick();
    chk("store_dm_valid_c3", 32'(dm_valid), 32'd1);
    tick();
    chk("store_dm_valid_c4", 32'(dm_valid), 32'd0);
    dm_we = 1'b0; dm_wstrb = 4'h0;

    // kill during WAIT, then redirected fetch
    rv_delay = 2;
    if_req = 1'b1; if_addr = 32'h300;
    exp_acc.push_back(mk(32'h300, 1'b0, 32'h0, 4'h0));
    tick();
    rv_delay = 0;
    tick();
    if_kill = 1'b1; if_req = 1'b0;
    #1 chk("stall_if_kill", 32'(stall_if), 32'd0);
    tick();
    if_kill = 1'b0; if_req = 1'b1; if_addr = 32'h380;
    exp_acc.push_back(mk(32'h380, 1'b0, 32'h0, 4'h0));
    exp_if.push_back(mem_fn(32'h380));
    ticks(10);
    chk("redirect_acc_done", 32'(exp_acc.size()), 32'd0);
    chk("redirect_if_done", 32'(exp_if.size()), 32'd0);

    // kill during ISSUE before the grant
    gnt_wait = 2;
    if_req = 1'b1; if_addr = 32'h500;
    tick();
    chk("kill_issue_req_before", 32'(mem_req), 32'd1);
    if_kill = 1'b1; if_req = 1'b0;
    tick();
    chk("kill_issue_req_after", 32'(mem_req), 32'd0);
    if_kill = 1'b0; gnt_wait = 0;
    ticks(4);

    // stray rvalid while idle
    rv_pend = 1'b1; rv_wait = 0; rv_data = 32'h1234_5678;
    ticks(3);
    chk("stray_if_rdata", if_rdata, mem_fn(32'h380));
    chk("stray_dm_rdata", dm_rdata, mem_fn(32'h3000));

    // reset while waiting; the late response must be ignored
    rv_delay = 3;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600;
    exp_acc.push_back(mk(32'h600, 1'b0, 32'h0, 4'h0));
    ticks(2);
    rst = 1'b1;
    tick();
    chk("rstw_mem_req", 32'(mem_req), 32'd0);
    chk("rstw_mem_addr", mem_addr, 32'd0);
    chk("rstw_mem_we", 32'(mem_we), 32'd0);
    chk("rstw_dm_rdata", dm_rdata, 32'd0);
    chk("rstw_if_rdata", if_rdata, 32'd0);
    chk("rstw_dm_valid", 32'(dm_valid), 32'd0);
    rst = 1'b0; dm_req = 1'b0; rv_delay = 0;
    ticks(6);
    chk("rstw_stall_mem", 32'(stall_mem), 32'd0);
    chk("rstw_dm_rdata_late", dm_rdata, 32'd0);

    chk("final_acc_empty", 32'(exp_acc.size()), 32'd0);
    chk("final_if_empty", 32'(exp_if.size()), 32'd0);
    chk("final_dm_empty", 32'(exp_dm.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
